// File: rtl/counter_mod_step.sv
// Up/down counter with programmable modulo limit, variable step, wrap/saturate
// handling, registered terminal-count pulse and sticky over/underflow flag.
module counter_mod_step #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              load_n,
    input  logic              up_down,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              tc,
    output logic              ovf_sticky
);

    // One guard bit above the wider operand keeps the sum exact.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [AW-1:0]    cnt_ext;
    logic [AW-1:0]    lim_ext;
    logic [AW-1:0]    step_ext;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    diff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt_cnt;
    logic             nxt_evt;

    assign cnt_ext  = AW'(count_out);
    assign lim_ext  = AW'(limit);
    assign step_ext = AW'(step);
    assign sum      = cnt_ext + step_ext;
    assign diff     = cnt_ext - step_ext;
    assign load_val = (data_load > limit) ? limit : data_load;

    always_comb begin
        nxt_cnt = count_out;
        nxt_evt = 1'b0;
        if (step_ext == '0) begin
            nxt_cnt = count_out;
        end else if (up_down) begin
            if (sum <= lim_ext) begin
                nxt_cnt = sum[WIDTH-1:0];
            end else begin
                nxt_evt = 1'b1;
                nxt_cnt = sat_mode ? limit : '0;
            end
        end else begin
            if (step_ext > cnt_ext) begin
                nxt_evt = 1'b1;
                nxt_cnt = sat_mode ? '0 : limit;
            end else if (diff > lim_ext) begin
                // Limit dropped below the count: clamp silently.
                nxt_cnt = limit;
            end else begin
                nxt_cnt = diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_out  <= '0;
            tc         <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (!load_n) begin
            count_out  <= load_val;
            tc         <= 1'b0;
            ovf_sticky <= ovf_sticky & ~clr_ovf;
        end else if (ce) begin
            count_out  <= nxt_cnt;
            tc         <= nxt_evt;
            ovf_sticky <= nxt_evt | (ovf_sticky & ~clr_ovf);
        end else begin
            tc         <= 1'b0;
            ovf_sticky <= ovf_sticky & ~clr_ovf;
        end
    end

    assign max_count = (count_out == limit);
    assign zero      = (count_out == '0);

endmodule

// File: tb/tb_counter_mod_step.sv
// Scoreboard bench for counter_mod_step: the driver queues hand-computed
// expectations per clock, a monitor pops and compares after each edge.
module tb_counter_mod_step;

    logic       clk = 1'b0;
    logic       rst, ce, load_n, up_down, sat_mode, clr_ovf;
    logic [3:0] step;
    logic [7:0] limit, data_load;
    logic [7:0] count_out;
    logic       max_count, zero, tc, ovf_sticky;

    typedef struct {
        logic [7:0] cnt;
        logic       mx;
        logic       zr;
        logic       tc;
        logic       ovf;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vec_id = 0;

    counter_mod_step #(.WIDTH(8), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .load_n(load_n), .up_down(up_down),
        .sat_mode(sat_mode), .step(step), .limit(limit), .data_load(data_load),
        .clr_ovf(clr_ovf), .count_out(count_out), .max_count(max_count),
        .zero(zero), .tc(tc), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    // Queue the state expected after the coming edge, then advance one cycle.
    task automatic vec(input logic [7:0] c, input logic t, input logic o);
        exp_t e;
        e.cnt = c;
        e.mx  = (c == limit);
        e.zr  = (c == 8'd0);
        e.tc  = t;
        e.ovf = o;
        e.id  = vec_id;
        vec_id++;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (count_out !== e.cnt || max_count !== e.mx || zero !== e.zr ||
                tc !== e.tc || ovf_sticky !== e.ovf) begin
                n_err++;
                $display("FAIL vec%0d: got cnt=%0d max=%b zero=%b tc=%b ovf=%b, want cnt=%0d max=%b zero=%b tc=%b ovf=%b",
                         e.id, count_out, max_count, zero, tc, ovf_sticky,
                         e.cnt, e.mx, e.zr, e.tc, e.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ce = 1'b0; load_n = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
        clr_ovf = 1'b0; step = 4'd0; limit = 8'd9; data_load = 8'd0;
        @(negedge clk);

        // reset
        vec(8'd0, 1'b0, 1'b0);
        vec(8'd0, 1'b0, 1'b0);
        rst = 1'b1;
        vec(8'd0, 1'b0, 1'b0);

        // up, wrap, limit 9
        ce = 1'b1; step = 4'd1;
        for (int i = 1; i <= 9; i++) vec(8'(i), 1'b0, 1'b0);
        vec(8'd0, 1'b1, 1'b1);
        vec(8'd1, 1'b0, 1'b1);
        vec(8'd2, 1'b0, 1'b1);

        // up, saturate, step 4
        ce = 1'b0; rst = 1'b0;
        vec(8'd0, 1'b0, 1'b0);
        rst = 1'b1; ce = 1'b1; step = 4'd4; sat_mode = 1'b1;
        vec(8'd4, 1'b0, 1'b0);
        vec(8'd8, 1'b0, 1'b0);
        vec(8'd9, 1'b1, 1'b1);
        vec(8'd9, 1'b1, 1'b1);
        ce = 1'b0;
        vec(8'd9, 1'b0, 1'b1);

        // clear without event
        clr_ovf = 1'b1;
        vec(8'd9, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // load clamped by limit, then down wrap step 3
        limit = 8'd15; data_load = 8'd20; load_n = 1'b0;
        vec(8'd15, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b0; step = 4'd3; sat_mode = 1'b0;
        vec(8'd12, 1'b0, 1'b0);
        vec(8'd9, 1'b0, 1'b0);
        vec(8'd6, 1'b0, 1'b0);
        vec(8'd3, 1'b0, 1'b0);
        vec(8'd0, 1'b0, 1'b0);
        vec(8'd15, 1'b1, 1'b1);

        // clr_ovf with same-cycle event keeps flag, then clears
        up_down = 1'b1; step = 4'd1; clr_ovf = 1'b1;
        vec(8'd0, 1'b1, 1'b1);
        ce = 1'b0;
        vec(8'd0, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // limit lowered below count
        limit = 8'd60; data_load = 8'd50; load_n = 1'b0;
        vec(8'd50, 1'b0, 1'b0);
        load_n = 1'b1; limit = 8'd30; ce = 1'b1; up_down = 1'b0; step = 4'd2;
        vec(8'd30, 1'b0, 1'b0);
        up_down = 1'b1; step = 4'd1;
        vec(8'd0, 1'b1, 1'b1);

        // up from above limit in sat mode, then step 0 at bound
        limit = 8'd60; load_n = 1'b0; ce = 1'b0;
        vec(8'd50, 1'b0, 1'b1);
        limit = 8'd30; load_n = 1'b1; ce = 1'b1; sat_mode = 1'b1;
        vec(8'd30, 1'b1, 1'b1);
        step = 4'd0;
        vec(8'd30, 1'b0, 1'b1);

        // down underflow in sat mode
        data_load = 8'd2; load_n = 1'b0; ce = 1'b0;
        vec(8'd2, 1'b0, 1'b1);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b0; step = 4'd3;
        vec(8'd0, 1'b1, 1'b1);

        // load beats ce
        data_load = 8'd5; load_n = 1'b0; up_down = 1'b1; step = 4'd1;
        vec(8'd5, 1'b0, 1'b1);
        load_n = 1'b1;
        vec(8'd6, 1'b0, 1'b1);

        // reset mid-count overrides everything
        rst = 1'b0; load_n = 1'b0; data_load = 8'd7; clr_ovf = 1'b0;
        vec(8'd0, 1'b0, 1'b0);
        rst = 1'b1; load_n = 1'b1;
        vec(8'd1, 1'b0, 1'b0);

        ce = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
